multicore_feeder: RTL and testbench

Input-side responder for the multicore neural-network array: serves the 4-bit `req_in` requests raised by the `rede_float` cores, supplying samples on the shared `io_in` bus. Samples arrive on a valid/ready stream into an internal FIFO. A round-robin arbiter grants one requesting core at a time and drives one sample with a one-hot grant under a 4-phase handshake. The block sits between the sample source and the array, in the same clock domain.

---
 rtl/multicore_pkg.sv | 19 +
 rtl/sample_fifo.sv | 47 ++++
 rtl/multicore_feeder.sv | 139 +++++++++++++
 tb/tb_multicore_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// rtl/multicore_pkg.sv - shared constants and types for the multicore feeder
package multicore_pkg;

    localparam int N_CORES    = 33;
    localparam int IN_W       = 19;
    localparam int OUT_W      = 28;
    localparam int REQ_W      = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 255;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    typedef logic signed [IN_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO, extra pointer bit separates full from empty
module sample_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic [W-1:0] mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/multicore_feeder.sv
// rtl/multicore_feeder.sv - round-robin sample server for the core array
module multicore_feeder #(
    parameter int N_CORES    = multicore_pkg::N_CORES,
    parameter int IN_W       = multicore_pkg::IN_W,
    parameter int REQ_W      = multicore_pkg::REQ_W,
    parameter int FIFO_DEPTH = multicore_pkg::FIFO_DEPTH,
    parameter int TIMEOUT    = multicore_pkg::TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    input  logic signed [IN_W-1:0]    s_data,
    output logic                      s_ready,
    input  logic [N_CORES*REQ_W-1:0]  req_in,
    output logic signed [IN_W-1:0]    io_in,
    output logic [N_CORES-1:0]        gnt,
    output logic [REQ_W-1:0]          gnt_code,
    output logic [15:0]               served,
    output logic                      err_timeout
);

    import multicore_pkg::*;

    localparam int IDW = $clog2(N_CORES);
    localparam int TW  = $clog2(TIMEOUT + 1);

    state_t              state_q;
    logic [IDW-1:0]      last_q;
    logic [IDW-1:0]      id_q;
    logic [TW-1:0]       tmr_q;
    logic [N_CORES-1:0]  gnt_q;
    logic [IN_W-1:0]     io_q;
    logic [REQ_W-1:0]    code_q;
    logic [15:0]         served_q;
    logic                err_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [IN_W-1:0]     fifo_data;
    logic [IDW:0]        pick;
    logic [IDW-1:0]      pick_id;
    logic                can_grant;
    logic                pop;
    logic [REQ_W-1:0]    cur_code;

    // Returns {found, id}; the descending scan leaves the core nearest to last+1.
    function automatic logic [IDW:0] rr_pick(input logic [N_CORES*REQ_W-1:0] req,
                                             input logic [IDW-1:0] last);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int i = N_CORES; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= N_CORES) begin
                idx = idx - N_CORES;
            end
            if (req[idx*REQ_W +: REQ_W] != '0) begin
                r = {1'b1, IDW'(idx)};
            end
        end
        return r;
    endfunction

    assign pick      = rr_pick(req_in, last_q);
    assign pick_id   = pick[IDW-1:0];
    assign can_grant = pick[IDW] && !fifo_empty;
    assign pop       = can_grant && (state_q != GRANT);
    assign cur_code  = req_in[id_q*REQ_W +: REQ_W];

    sample_fifo #(
        .W     (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s_valid),
        .data_i  (s_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // RELEASE also arbitrates so the next grant can follow after a single low cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDW'(N_CORES - 1);
            id_q     <= '0;
            tmr_q    <= '0;
            gnt_q    <= '0;
            io_q     <= '0;
            code_q   <= '0;
            served_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RELEASE: begin
                    if (can_grant) begin
                        id_q     <= pick_id;
                        last_q   <= pick_id;
                        io_q     <= fifo_data;
                        code_q   <= req_in[pick_id*REQ_W +: REQ_W];
                        gnt_q    <= N_CORES'(1) << pick_id;
                        served_q <= served_q + 16'd1;
                        tmr_q    <= '0;
                        state_q  <= GRANT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                GRANT: begin
                    if (cur_code == '0) begin
                        gnt_q   <= '0;
                        state_q <= RELEASE;
                    end else if (tmr_q == TW'(TIMEOUT)) begin
                        gnt_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end else begin
                        tmr_q   <= tmr_q + TW'(1);
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready     = !fifo_full;
    assign io_in       = io_q;
    assign gnt         = gnt_q;
    assign gnt_code    = code_q;
    assign served      = served_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_multicore_feeder.sv
// tb/tb_multicore_feeder.sv - randomized directed bench for multicore_feeder
module tb_multicore_feeder;

    localparam int N     = 33;
    localparam int W     = 19;
    localparam int RW    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 255;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic [W-1:0]    s_data = '0;
    logic            s_ready;
    logic [N*RW-1:0] req_in = '0;
    logic [W-1:0]    io_in;
    logic [N-1:0]    gnt;
    logic [RW-1:0]   gnt_code;
    logic [15:0]     served;
    logic            err_timeout;

    logic [W-1:0]    q[$];
    logic [W-1:0]    last_d = '0;
    int              last_m = N - 1;
    int              served_m = 0;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    multicore_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .req_in      (req_in),
        .io_in       (io_in),
        .gnt         (gnt),
        .gnt_code    (gnt_code),
        .served      (served),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_code(input int k, input logic [RW-1:0] c);
        req_in[k*RW +: RW] = c;
    endtask

    function automatic logic [RW-1:0] rnd_code();
        return RW'($urandom_range(1, 15));
    endfunction

    // Next core to serve: first nonzero code scanning upward from the last served core.
    function automatic int rr_expect();
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last_m + i) % N;
            if (req_in[k*RW +: RW] != '0) return k;
        end
        return 0;
    endfunction

    task automatic push_one(input logic [W-1:0] v);
        s_valid = 1'b1;
        s_data  = v;
        if (q.size() < DEPTH) q.push_back(v);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input int max_wait, input int exp_lat);
        int           n;
        int           k;
        logic [W-1:0] exp_d;
        logic [63:0]  one;
        n   = 0;
        one = 64'd1;
        k   = rr_expect();
        while (gnt == '0 && n < max_wait) begin
            tick();
            n++;
        end
        exp_d = (q.size() > 0) ? q.pop_front() : '0;
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_gnt"}, 64'(gnt), one << k);
        chk({tag, "_io"}, 64'(io_in), 64'(exp_d));
        chk({tag, "_code"}, 64'(gnt_code), 64'(req_in[k*RW +: RW]));
        served_m = (served_m + 1) & 16'hFFFF;
        chk({tag, "_served"}, 64'(served), 64'(served_m));
        last_m = k;
        last_d = exp_d;
    endtask

    task automatic release_grant(input string tag);
        set_code(last_m, '0);
        tick();
        chk({tag, "_rel_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_rel_io"}, 64'(io_in), 64'(last_d));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] c1;
        logic [RW-1:0] c2;
        int            h;
        int            k;

        tick();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_io", 64'(io_in), 64'd0);
        chk("rst_code", 64'(gnt_code), 64'd0);
        chk("rst_served", 64'(served), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        push_one(W'(100));
        push_one(W'(-200));
        set_code(5, 4'd1);
        expect_grant("c5_first", 4, 1);
        release_grant("c5_first");
        set_code(5, 4'd1);
        expect_grant("c5_second", 4, 1);
        release_grant("c5_second");
        tick();

        push_one(W'($urandom));
        push_one(W'($urandom));
        set_code(9, rnd_code());
        expect_grant("pre_rst", 4, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_served", 64'(served), 64'd0);
        chk("midrst_ready", 64'(s_ready), 64'd1);
        chk("midrst_io", 64'(io_in), 64'd0);
        req_in = '0;
        q.delete();
        last_m   = N - 1;
        served_m = 0;
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) push_one(W'($urandom));
        set_code(0, rnd_code());
        set_code(7, rnd_code());
        set_code(32, rnd_code());
        expect_grant("rr_0", 4, 1);
        release_grant("rr_0");
        expect_grant("rr_7", 4, 1);
        c1 = gnt_code;
        c2 = (c1 == 4'd15) ? 4'd1 : c1 + 4'd1;
        set_code(7, c2);
        tick();
        chk("rr_7_code_hold", 64'(gnt_code), 64'(c1));
        chk("rr_7_gnt_hold", 64'(gnt), 64'd1 << 7);
        release_grant("rr_7");
        expect_grant("rr_32", 4, 1);
        release_grant("rr_32");
        tick();
        push_one(W'($urandom));
        set_code(0, rnd_code());
        expect_grant("rr_0_again", 4, 1);
        release_grant("rr_0_again");
        tick();

        set_code(3, rnd_code());
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("empty_wait", 64'(gnt), 64'd0);
        end
        push_one(W'(42));
        chk("b2b_no_gnt_yet", 64'(gnt), 64'd0);
        expect_grant("b2b_c3", 4, 1);
        release_grant("b2b_c3");
        tick();

        for (int i = 0; i < DEPTH; i++) push_one(W'($urandom));
        chk("full_ready", 64'(s_ready), 64'd0);
        push_one(W'($urandom));
        chk("full_17th", 64'(s_ready), 64'd0);
        set_code(int'($urandom_range(0, N - 1)), rnd_code());
        expect_grant("drain_first", 4, 1);
        chk("ready_after_pop", 64'(s_ready), 64'd1);
        release_grant("drain_first");
        while (q.size() > 0) begin
            set_code(int'($urandom_range(0, N - 1)), rnd_code());
            expect_grant("drain", 4, 1);
            release_grant("drain");
        end
        tick();

        push_one(W'($urandom));
        k = int'($urandom_range(0, N - 1));
        set_code(k, rnd_code());
        expect_grant("tmo", 4, 1);
        chk("tmo_err_before", 64'(err_timeout), 64'd0);
        h = 1;
        while (gnt != '0 && h < 600) begin
            tick();
            if (gnt != '0) h++;
        end
        chk("tmo_hold_cycles", 64'(h), 64'(TMO + 1));
        chk("tmo_err_set", 64'(err_timeout), 64'd1);
        chk("tmo_gnt_drop", 64'(gnt), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("tmo_no_regrant", 64'(gnt), 64'd0);
        req_in = '0;
        for (int i = 0; i < 3; i++) tick();
        chk("tmo_err_sticky", 64'(err_timeout), 64'd1);
        chk("tmo_served", 64'(served), 64'(served_m));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
